// File: rtl/layer_sequencer.sv
// Walks a programmable table of layer descriptors, issuing each config to TOP with a start pulse.
// Define LAYER_SEQ_PERF_EN to add per-layer cycle counters readable through perf_addr/perf_rdata.
module layer_sequencer #(
    parameter int unsigned MAX_LAYERS = 32,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned DESC_W     = 37
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DESC_W-1:0] cfg_wdata,
    input  logic [IDX_W:0]    num_layers,
    input  logic              seq_start,
    input  logic              seq_abort,
`ifdef LAYER_SEQ_PERF_EN
    input  logic [IDX_W-1:0]  perf_addr,
    output logic [31:0]       perf_rdata,
`endif
    input  logic              top_done,
    output logic              top_start,
    output logic [8:0]        ifm_size,
    output logic [10:0]       ifm_channel,
    output logic [1:0]        kernel_size,
    output logic [10:0]       num_filter,
    output logic              maxpool_mode,
    output logic [1:0]        maxpool_stride,
    output logic              upsample_mode,
    output logic [IDX_W-1:0]  cur_layer,
    output logic              busy,
    output logic              seq_done,
    output logic              seq_err
);

    typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWaitDone, StNext, StError} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [IDX_W:0]    num_q, num_d;
    logic              err_q, err_d;
    logic              seq_done_q, seq_done_d;
    logic              done_prev_q;
    logic [DESC_W-1:0] desc_q, desc_d;
    logic [DESC_W-1:0] table_q [MAX_LAYERS];

    logic             done_rise;
    logic             desc_legal;
    logic             last_layer;
    logic             table_we;
    logic [IDX_W-1:0] index_inc;

    assign {ifm_size, ifm_channel, kernel_size, num_filter,
            maxpool_mode, maxpool_stride, upsample_mode} = desc_q;

    assign done_rise  = top_done && !done_prev_q;
    assign index_inc  = index_q + IDX_W'(1);
    assign last_layer = ({1'b0, index_q} + (IDX_W+1)'(1)) == num_q;
    assign table_we   = cfg_we && (state_q == StIdle || state_q == StError);

    // Checked against the descriptor already sitting on the config outputs during LOAD.
    assign desc_legal = (kernel_size == 2'd1 || kernel_size == 2'd3)
                     && !(maxpool_mode && upsample_mode)
                     && (!maxpool_mode || maxpool_stride == 2'd1 || maxpool_stride == 2'd2)
                     && (ifm_size >= 9'(kernel_size))
                     && (ifm_channel != '0) && (num_filter != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            index_q     <= '0;
            num_q       <= '0;
            err_q       <= 1'b0;
            seq_done_q  <= 1'b0;
            done_prev_q <= 1'b0;
            desc_q      <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            num_q       <= num_d;
            err_q       <= err_d;
            seq_done_q  <= seq_done_d;
            done_prev_q <= top_done;
            desc_q      <= desc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (table_we) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        num_d      = num_q;
        err_d      = err_q;
        seq_done_d = 1'b0;
        desc_d     = desc_q;
        unique case (state_q)
            StIdle, StError: begin
                if (seq_start && !seq_abort) begin
                    num_d   = num_layers;
                    index_d = '0;
                    err_d   = 1'b0;
                    if (num_layers == '0) begin
                        seq_done_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        desc_d  = table_q[0];
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (seq_abort) begin
                    state_d = StIdle;
                end else if (!desc_legal) begin
                    err_d   = 1'b1;
                    state_d = StError;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = seq_abort ? StIdle : StWaitDone;
            end
            StWaitDone: begin
                if (seq_abort) begin
                    state_d = StIdle;
                end else if (done_rise) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (seq_abort) begin
                    state_d = StIdle;
                end else if (last_layer) begin
                    seq_done_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    index_d = index_inc;
                    desc_d  = table_q[index_inc];
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        top_start = (state_q == StIssue) && !seq_abort;
        busy      = (state_q == StLoad) || (state_q == StIssue)
                 || (state_q == StWaitDone) || (state_q == StNext);
        cur_layer = index_q;
        seq_done  = seq_done_q;
        seq_err   = err_q;
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] perf_tab_q [MAX_LAYERS];

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (state_q == StLoad) begin
            perf_cnt_d = '0;
        end else if ((state_q == StIssue || state_q == StWaitDone) && perf_cnt_q != '1) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == StWaitDone && done_rise && !seq_abort) begin
            perf_tab_q[index_q] <= perf_cnt_q;
        end
    end

    assign perf_rdata = perf_tab_q[perf_addr];
`else
    // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, cfg_we, seq_start, seq_abort, top_done;
    logic [4:0]  cfg_addr;
    logic [36:0] cfg_wdata;
    logic [5:0]  num_layers;
    logic        top_start, maxpool_mode, upsample_mode, busy, seq_done, seq_err;
    logic [8:0]  ifm_size;
    logic [10:0] ifm_channel, num_filter;
    logic [1:0]  kernel_size, maxpool_stride;
    logic [4:0]  cur_layer;
`ifdef LAYER_SEQ_PERF_EN
    logic [4:0]  perf_addr = '0;
    logic [31:0] perf_rdata;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int start_cyc_log [64];
    int start_layer_log [64];

    layer_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .num_layers     (num_layers),
        .seq_start      (seq_start),
        .seq_abort      (seq_abort),
`ifdef LAYER_SEQ_PERF_EN
        .perf_addr      (perf_addr),
        .perf_rdata     (perf_rdata),
`endif
        .top_done       (top_done),
        .top_start      (top_start),
        .ifm_size       (ifm_size),
        .ifm_channel    (ifm_channel),
        .kernel_size    (kernel_size),
        .num_filter     (num_filter),
        .maxpool_mode   (maxpool_mode),
        .maxpool_stride (maxpool_stride),
        .upsample_mode  (upsample_mode),
        .cur_layer      (cur_layer),
        .busy           (busy),
        .seq_done       (seq_done),
        .seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (top_start === 1'b1) begin
            if (start_cnt < 64) begin
                start_cyc_log[start_cnt]   <= cyc;
                start_layer_log[start_cnt] <= int'(cur_layer);
            end
            start_cnt <= start_cnt + 1;
        end
        if (seq_done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] mk(int ifm, int ch, int k, int nf, int mp, int st, int up);
        return {ifm[8:0], ch[10:0], k[1:0], nf[10:0], mp[0], st[1:0], up[0]};
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_desc(int addr, logic [36:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = addr[4:0];
        cfg_wdata = d;
        step(1);
        cfg_we    = 1'b0;
    endtask

    task automatic start_seq(int n);
        num_layers = n[5:0];
        seq_start  = 1'b1;
        step(1);
        seq_start  = 1'b0;
    endtask

    // Waits (bounded) until the monitor has logged `target` start pulses in total.
    task automatic wait_starts(int target, string name);
        for (int k = 0; k < 60 && start_cnt < target; k++) step(1);
        vectors++;
        if (start_cnt < target) begin
            miscompares++;
            $display("FAIL %s: start pulses seen %0d, required %0d", name, start_cnt, target);
        end
    endtask

    task automatic done_pulse(output int d);
        top_done = 1'b1;
        d = cyc;
        step(2);
        top_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        @(negedge clk);
        vectors++;
        if ({top_start, busy, seq_done, seq_err} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, required 0000", {top_start, busy, seq_done, seq_err});
        end
        vectors++;
        if ({ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode, maxpool_stride,
             upsample_mode, cur_layer} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_cfg: config/cur_layer not zero (ifm_size=%0d cur_layer=%0d)",
                     ifm_size, cur_layer);
        end
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        int s, d, b, bd;
        write_desc(0, mk(13, 256, 1, 128, 0, 0, 1));
        b  = start_cnt;
        bd = done_cnt;
        s  = cyc;
        start_seq(1);
        @(negedge clk);
        vectors++;
        if ({ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode, maxpool_stride,
             upsample_mode} !== {9'd13, 11'd256, 2'd1, 11'd128, 1'b0, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_cfg: got %0d/%0d/%0d/%0d/%0d/%0d/%0d, required 13/256/1/128/0/0/1",
                     ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode,
                     maxpool_stride, upsample_mode);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_load: busy=%b, required 1", busy);
        end
        while (cyc < s + 490) step(1);
        done_pulse(d);
        step(2);
        @(negedge clk);
        vectors++;
        if (start_cnt - b !== 1 || start_cyc_log[b] !== s + 2) begin
            miscompares++;
            $display("FAIL single_start: pulses=%0d at cycle %0d, required 1 at %0d",
                     start_cnt - b, start_cyc_log[b], s + 2);
        end
        vectors++;
        if (done_cnt - bd !== 1 || last_done_cyc !== d + 2) begin
            miscompares++;
            $display("FAIL single_done: pulses=%0d at cycle %0d, required 1 at %0d",
                     done_cnt - bd, last_done_cyc, d + 2);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy_after: busy=%b, required 0", busy);
        end
        step(1);
    endtask

    task automatic test_three_layers();
        int b, bd, dd;
        int d [3];
        write_desc(0, mk(26, 16, 3, 32, 1, 2, 0));
        write_desc(1, mk(13, 32, 3, 64, 1, 1, 0));
        write_desc(2, mk(13, 64, 1, 16, 0, 0, 1));
        b  = start_cnt;
        bd = done_cnt;
        start_seq(3);
        for (int i = 0; i < 3; i++) begin
            wait_starts(b + i + 1, "three_wait_start");
            step(4);
            top_done = 1'b1;
            d[i] = cyc;
            // Layer 0 holds done long past the next issue to prove a level does not re-advance.
            step(i == 0 ? 20 : 2);
            top_done = 1'b0;
            step(1);
        end
        step(3);
        @(negedge clk);
        vectors++;
        if (start_cnt - b !== 3) begin
            miscompares++;
            $display("FAIL three_count: start pulses=%0d, required 3", start_cnt - b);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (start_layer_log[b + i] !== i) begin
                miscompares++;
                $display("FAIL three_cur_layer: pulse %0d cur_layer=%0d, required %0d",
                         i, start_layer_log[b + i], i);
            end
        end
        for (int i = 1; i < 3; i++) begin
            vectors++;
            if (start_cyc_log[b + i] !== d[i - 1] + 3) begin
                miscompares++;
                $display("FAIL three_gap: pulse %0d at cycle %0d, required %0d",
                         i, start_cyc_log[b + i], d[i - 1] + 3);
            end
        end
        dd = d[2] + 2;
        vectors++;
        if (done_cnt - bd !== 1 || last_done_cyc !== dd) begin
            miscompares++;
            $display("FAIL three_done: pulses=%0d at cycle %0d, required 1 at %0d",
                     done_cnt - bd, last_done_cyc, dd);
        end
    endtask

    task automatic test_illegal();
        int b, bd, d;
        write_desc(0, mk(8, 4, 3, 4, 0, 0, 0));
        write_desc(1, mk(8, 4, 3, 4, 1, 1, 1));
        b  = start_cnt;
        bd = done_cnt;
        start_seq(2);
        wait_starts(b + 1, "illegal_wait_start");
        step(3);
        done_pulse(d);
        while (cyc < d + 4) step(1);
        @(negedge clk);
        vectors++;
        if (seq_err !== 1'b1 || cur_layer !== 5'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_err: seq_err=%b cur_layer=%0d busy=%b, required 1/1/0",
                     seq_err, cur_layer, busy);
        end
        step(5);
        vectors++;
        if (start_cnt - b !== 1 || done_cnt !== bd) begin
            miscompares++;
            $display("FAIL illegal_no_issue: starts=%0d dones=%0d, required 1/0",
                     start_cnt - b, done_cnt - bd);
        end
        start_seq(1);
        @(negedge clk);
        vectors++;
        if (seq_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_clear: seq_err=%b busy=%b, required 0/1", seq_err, busy);
        end
        wait_starts(b + 2, "illegal_restart");
        step(2);
        done_pulse(d);
        step(3);
    endtask

    task automatic test_zero_layers();
        int b, bd;
        b  = start_cnt;
        bd = done_cnt;
        start_seq(0);
        @(negedge clk);
        vectors++;
        if (seq_done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: seq_done=%b busy=%b, required 1/0", seq_done, busy);
        end
        step(1);
        @(negedge clk);
        vectors++;
        if (seq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pulse_width: seq_done=%b, required 0", seq_done);
        end
        // Abort alongside start from IDLE must keep the sequencer idle.
        seq_abort = 1'b1;
        start_seq(1);
        seq_abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start_idle: busy=%b, required 0", busy);
        end
        step(4);
        vectors++;
        if (start_cnt !== b || done_cnt - bd !== 1) begin
            miscompares++;
            $display("FAIL zero_no_start: starts=%0d dones=%0d, required 0/1",
                     start_cnt - b, done_cnt - bd);
        end
    endtask

    task automatic test_abort();
        int b, bd, d;
        for (int i = 0; i < 4; i++) write_desc(i, mk(10 + i, 8, 1, 8, 0, 0, 0));
        b  = start_cnt;
        bd = done_cnt;
        start_seq(4);
        wait_starts(b + 1, "abort_wait_l0");
        step(2);
        done_pulse(d);
        wait_starts(b + 2, "abort_wait_l1");
        step(1);
        write_desc(1, mk(99, 8, 1, 8, 0, 0, 0));
        // Done edge and abort together: abort must win.
        seq_abort = 1'b1;
        top_done  = 1'b1;
        step(1);
        seq_abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || top_start !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%b top_start=%b, required 0/0", busy, top_start);
        end
        step(6);
        top_done = 1'b0;
        vectors++;
        if (start_cnt - b !== 2 || done_cnt !== bd) begin
            miscompares++;
            $display("FAIL abort_quiet: starts=%0d dones=%0d, required 2/0",
                     start_cnt - b, done_cnt - bd);
        end
        step(2);
        start_seq(2);
        wait_starts(b + 3, "abort_rerun_l0");
        step(2);
        done_pulse(d);
        wait_starts(b + 4, "abort_rerun_l1");
        @(negedge clk);
        vectors++;
        if (ifm_size !== 9'd11 || cur_layer !== 5'd1) begin
            miscompares++;
            $display("FAIL abort_table_kept: ifm_size=%0d cur_layer=%0d, required 11/1",
                     ifm_size, cur_layer);
        end
        step(2);
        done_pulse(d);
        step(3);
        vectors++;
        if (done_cnt - bd !== 1) begin
            miscompares++;
            $display("FAIL abort_rerun_done: dones=%0d, required 1", done_cnt - bd);
        end
    endtask

    task automatic test_reset_in_issue();
        int s;
        write_desc(0, mk(5, 3, 3, 7, 0, 0, 0));
        s = cyc;
        start_seq(1);
        step(1);
        @(negedge clk);
        vectors++;
        if (top_start !== 1'b1 || cyc !== s + 2) begin
            miscompares++;
            $display("FAIL rst_issue_pre: top_start=%b at cycle %0d, required 1 at %0d",
                     top_start, cyc, s + 2);
        end
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        vectors++;
        if ({top_start, busy, ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode,
             maxpool_stride, upsample_mode} !== 39'd0) begin
            miscompares++;
            $display("FAIL rst_issue_post: top_start=%b busy=%b ifm_size=%0d kernel=%0d, required 0",
                     top_start, busy, ifm_size, kernel_size);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        num_layers = '0;
        seq_start  = 1'b0;
        seq_abort  = 1'b0;
        top_done   = 1'b0;
        test_reset();
        test_single();
        test_three_layers();
        test_illegal();
        test_zero_layers();
        test_abort();
        test_reset_in_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences the systolic-array TOP through a multi-layer network (conv / conv+maxpool / conv+upsample) without testbench or CPU intervention per layer.
- Holds a programmable descriptor table of layer configs and, for each entry, drives TOP's config ports, pulses start and waits for done.
- Validates each descriptor before issue and stops on an illegal one.
- Sits between the host/config interface and TOP's start/done/config ports.

Parameters:
- MAX_LAYERS, 32, descriptor table depth.
- IDX_W, 5, width of layer index (log2 MAX_LAYERS).
- DESC_W, 37, descriptor width; packing from MSB: ifm_size[8:0], ifm_channel[10:0], kernel_size[1:0], num_filter[10:0], maxpool_mode, maxpool_stride[1:0], upsample_mode.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  descriptor write strobe
- cfg_addr  in  IDX_W  descriptor write index
- cfg_wdata  in  DESC_W  descriptor data
- num_layers  in  IDX_W+1  layers to run, 0..MAX_LAYERS; sampled at seq_start
- seq_start  in  1  start-sequence pulse
- seq_abort  in  1  abort request
- top_done  in  1  TOP done (level or pulse)
- top_start  out  1  one-cycle start pulse to TOP
- ifm_size  out  9;  ifm_channel  out  11;  kernel_size  out  2;  num_filter  out  11;  maxpool_mode  out  1;  maxpool_stride  out  2;  upsample_mode  out  1  registered layer config to TOP
- cur_layer  out  IDX_W  index of layer in flight
- busy  out  1  high from LOAD through WAIT_DONE
- seq_done  out  1  one-cycle pulse when all layers completed
- seq_err  out  1  sticky illegal-descriptor flag

Behaviour:
- Reset (rst_n low at posedge):
  - state = IDLE.
  - All outputs 0, including the config outputs.
  - Table contents are not reset.
- FSM states: IDLE, LOAD, ISSUE, WAIT_DONE, NEXT, ERROR.
- IDLE:
  - Accepts cfg_we; writes table[cfg_addr].
  - On seq_start: latch num_layers, clear seq_err and index.
  - num_layers == 0: pulse seq_done next cycle, stay IDLE, never assert top_start.
  - Otherwise go to LOAD.
- LOAD:
  - Register table[index] onto the config outputs; cur_layer = index.
  - Legality check:
    - kernel_size in {1,3}.
    - Not (maxpool_mode and upsample_mode).
    - maxpool_mode = 1 requires maxpool_stride in {1,2}.
    - ifm_size >= kernel_size.
    - ifm_channel != 0 and num_filter != 0.
  - Illegal: go to ERROR. Legal: go to ISSUE.
- ISSUE: top_start = 1 for exactly this cycle; go to WAIT_DONE.
- Start latency: seq_start at cycle N, LOAD at N+1, top_start high at N+2.
- Config outputs are stable from LOAD until the next LOAD, so they are always stable at least one cycle before top_start.
- WAIT_DONE:
  - Advance only on a rising edge of top_done (registered previous-value compare). A done level held over from the prior layer must not advance the sequence.
  - On edge go to NEXT.
- NEXT:
  - index == latched num_layers-1: seq_done = 1 for one cycle, go to IDLE.
  - Otherwise index++, go to LOAD.
  - Inter-layer gap: top_done edge at cycle M gives next top_start at M+3.
- ERROR:
  - seq_err = 1, busy = 0.
  - cur_layer holds the failing index.
  - Stays in ERROR until seq_start, which clears seq_err and restarts from index 0.
  - cfg_we is accepted in ERROR.
- cfg_we while busy: ignored, table unchanged.
- seq_start while busy: ignored.
- seq_abort:
  - Valid in any busy state; next cycle state = IDLE.
  - top_start forced 0; no seq_done; seq_err unchanged.
  - TOP itself is not stopped; the host resets TOP.
- seq_abort and seq_start in the same cycle from IDLE: abort wins, stay IDLE.
- top_done edge and seq_abort in the same cycle: abort wins.
- rst_n low mid-sequence: immediate return to IDLE with all outputs 0 on the next edge.

Optional Feature:
- Macro: LAYER_SEQ_PERF_EN.
- When defined:
  - A 32-bit cycle counter runs while in ISSUE/WAIT_DONE.
  - On each top_done edge the count is written to an internal perf table[cur_layer]; the counter clears at LOAD.
  - Extra ports: perf_addr in IDX_W, perf_rdata out 32 (combinational read).
  - Counter saturates at 2^32-1.
- When undefined: no counter, no perf ports; all other behaviour identical.

Test Plan:
- Single layer {13, 256, 1, 128, 0, 0, 1}, num_layers = 1, seq_start at cycle 10:
  - Outputs show 13/256/1/128/0/0/1 by cycle 11.
  - top_start high only at cycle 12.
  - top_done rise at cycle 500 gives seq_done pulse at cycle 502; busy low afterwards.
- Three layers (k3 maxpool stride2; k3 maxpool stride1; k1 upsample):
  - Exactly 3 top_start pulses.
  - cur_layer sequence 0, 1, 2.
  - Each top_start occurs 3 cycles after the preceding done edge.
  - top_done held high for 20 cycles causes no double advance.
- Descriptor 1 illegal (maxpool_mode = 1 and upsample_mode = 1):
  - Layer 0 runs normally.
  - After its done: seq_err = 1, cur_layer = 1, no second top_start.
  - A following seq_start clears seq_err.
- num_layers = 0: seq_done pulses one cycle after seq_start; top_start never asserts.
- seq_abort in WAIT_DONE of layer 1 of 4:
  - IDLE next cycle, busy = 0, no seq_done.
  - cfg_we during the run left the table unchanged (read back by rerunning).
- Reset asserted during ISSUE: top_start is 0 and all config outputs are 0 on the next cycle.
